pipe_stage_buf: RTL and testbench

Parametrised pipeline-stage register with a valid/ready handshake, an optional two-entry skid buffer and a flush input. It generalises the fixed ID/EX latch into a reusable stage for any boundary (IF/ID, ID/EX, EX/MEM, MEM/WB). Backpressure replaces the stall vector, and `discard` clears the stage on branch mispredict. The payload is an opaque bus, and stage modules pack and unpack their own fields into it.

---
 rtl/pipe_stage_buf.sv | 109 ++++++++++
 tb/tb_pipe_stage_buf.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// Reusable pipeline-stage register: valid/ready handshake, optional two-entry
// skid buffer (registered in_ready) and a discard input for branch flushes.
module pipe_stage_buf #(
  parameter int WIDTH      = 32,
  parameter int SKID       = 1,
  parameter int CLEAR_DATA = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             discard,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count,
  output logic             flushed
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and a stalled producer holds data.
  localparam bit USE_SKID = (SKID != 0);
  localparam bit CLR      = (CLEAR_DATA != 0);

  // Encoding equals the number of held entries, so count exposes the state.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   main_q, main_d;
  logic [WIDTH-1:0]   skid_q, skid_d;
  logic               flushed_q, flushed_d;
  logic               in_fire, out_fire;

  always_comb begin
    if (USE_SKID) in_ready = reset & (state_q != ST_FULL);
    else          in_ready = reset & ((state_q == ST_EMPTY) | out_ready);
  end

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign count     = state_q;
  assign flushed   = flushed_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d   = state_q;
    main_d    = main_q;
    skid_d    = skid_q;
    flushed_d = 1'b0;
    if (discard) begin
      // Flush wins over any handshake this cycle, including an input fire.
      state_d   = ST_EMPTY;
      flushed_d = (state_q != ST_EMPTY);
      if (CLR) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (in_fire && (out_fire || !USE_SKID)) begin
            main_d = in_data;
          end else if (in_fire) begin
            state_d = ST_FULL;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
            if (CLR) main_d = '0;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_d = ST_ONE;
            main_d  = skid_q;
            if (CLR) skid_d = '0;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      flushed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
      flushed_q <= flushed_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: skid instance with scoreboard, plus SKID=0 and
// CLEAR_DATA=0 instances exercised with directed scenarios.
module tb_pipe_stage_buf;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  int         checks = 0;
  int         failures = 0;
  bit         mon_en = 1'b0;
  logic [7:0] exp_q[$];

  // skid instance (WIDTH=8, SKID=1, CLEAR_DATA=1)
  logic       discard = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready, out_valid, flushed;
  logic [7:0] out_data;
  logic [1:0] count;

  // single-entry instance (SKID=0)
  logic       s0_discard = 1'b0, s0_in_valid = 1'b0, s0_out_ready = 1'b0;
  logic [7:0] s0_in_data = '0;
  logic       s0_in_ready, s0_out_valid, s0_flushed;
  logic [7:0] s0_out_data;
  logic [1:0] s0_count;

  // hold-data instance (CLEAR_DATA=0)
  logic       k_discard = 1'b0, k_in_valid = 1'b0, k_out_ready = 1'b0;
  logic [7:0] k_in_data = '0;
  logic       k_in_ready, k_out_valid, k_flushed;
  logic [7:0] k_out_data;
  logic [1:0] k_count;

  pipe_stage_buf #(.WIDTH(8), .SKID(1), .CLEAR_DATA(1)) u_dut (
    .clock(clock), .reset(reset), .discard(discard),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .flushed(flushed));

  pipe_stage_buf #(.WIDTH(8), .SKID(0), .CLEAR_DATA(1)) u_dut_s0 (
    .clock(clock), .reset(reset), .discard(s0_discard),
    .in_valid(s0_in_valid), .in_ready(s0_in_ready), .in_data(s0_in_data),
    .out_valid(s0_out_valid), .out_ready(s0_out_ready), .out_data(s0_out_data),
    .count(s0_count), .flushed(s0_flushed));

  pipe_stage_buf #(.WIDTH(8), .SKID(1), .CLEAR_DATA(0)) u_dut_k (
    .clock(clock), .reset(reset), .discard(k_discard),
    .in_valid(k_in_valid), .in_ready(k_in_ready), .in_data(k_in_data),
    .out_valid(k_out_valid), .out_ready(k_out_ready), .out_data(k_out_data),
    .count(k_count), .flushed(k_flushed));

  // clock / reset block
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // Scoreboard on the skid instance: sampled mid-cycle, away from the edge.
  always @(negedge clock) begin
    if (mon_en) begin
      checks++;
      if (count !== 2'(exp_q.size())) begin
        $display("FAIL sb_count: got %0d required %0d", count, exp_q.size());
        failures++;
      end
      if (!reset || discard) begin
        exp_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            $display("FAIL sb_order: got 0x%02h required nothing pending", out_data);
            failures++;
          end else begin
            if (out_data !== exp_q[0]) begin
              $display("FAIL sb_order: got 0x%02h required 0x%02h", out_data, exp_q[0]);
              failures++;
            end
            void'(exp_q.pop_front());
          end
        end
        if (in_valid && in_ready) exp_q.push_back(in_data);
      end
    end
  end

  // driver: move one cycle, new inputs land just after the rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    @(negedge clock);
    checks += 5;
    if (out_valid !== 1'b0) begin $display("FAIL rst_out_valid: got %b required 0", out_valid); failures++; end
    if (count !== 2'd0) begin $display("FAIL rst_count: got %0d required 0", count); failures++; end
    if (out_data !== 8'h00) begin $display("FAIL rst_out_data: got 0x%02h required 0x00", out_data); failures++; end
    if (flushed !== 1'b0) begin $display("FAIL rst_flushed: got %b required 0", flushed); failures++; end
    if (in_ready !== 1'b0) begin $display("FAIL rst_in_ready: got %b required 0", in_ready); failures++; end
    checks += 2;
    if (s0_count !== 2'd0 || s0_in_ready !== 1'b0) begin
      $display("FAIL rst_s0: got count=%0d in_ready=%b required 0/0", s0_count, s0_in_ready); failures++;
    end
    if (k_count !== 2'd0 || k_out_data !== 8'h00) begin
      $display("FAIL rst_k: got count=%0d data=0x%02h required 0/0x00", k_count, k_out_data); failures++;
    end
    tick();
    reset = 1'b1;
    mon_en = 1'b1;
    @(negedge clock);
    checks += 2;
    if (in_ready !== 1'b1) begin $display("FAIL rst_release_in_ready: got %b required 1", in_ready); failures++; end
    if (s0_in_ready !== 1'b1) begin $display("FAIL rst_release_s0_ready: got %b required 1", s0_in_ready); failures++; end
  endtask

  task automatic test_streaming();
    logic [7:0] vals [3] = '{8'h11, 8'h22, 8'h33};
    tick();
    in_valid = 1'b1; in_data = vals[0]; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i < 2) in_data = vals[i+1];
      else in_valid = 1'b0;
      @(negedge clock);
      checks += 3;
      if (out_data !== vals[i]) begin $display("FAIL stream_data%0d: got 0x%02h required 0x%02h", i, out_data, vals[i]); failures++; end
      if (count !== 2'd1) begin $display("FAIL stream_count%0d: got %0d required 1", i, count); failures++; end
      if (in_ready !== 1'b1) begin $display("FAIL stream_in_ready%0d: got %b required 1", i, in_ready); failures++; end
    end
    tick();
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b0) begin $display("FAIL stream_drain: got %b required 0", out_valid); failures++; end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hA1;
    tick();
    in_data = 8'hA2;
    tick();
    in_data = 8'hA3;
    @(negedge clock);
    checks += 3;
    if (count !== 2'd2) begin $display("FAIL bp_count: got %0d required 2", count); failures++; end
    if (in_ready !== 1'b0) begin $display("FAIL bp_in_ready: got %b required 0", in_ready); failures++; end
    if (out_data !== 8'hA1) begin $display("FAIL bp_head: got 0x%02h required 0xA1", out_data); failures++; end
    tick();
    @(negedge clock);
    checks++;
    if (count !== 2'd2 || out_data !== 8'hA1) begin
      $display("FAIL bp_hold: got count=%0d data=0x%02h required 2/0xA1", count, out_data); failures++;
    end
    tick();
    out_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b0) begin $display("FAIL bp_ready_reg: got %b required 0", in_ready); failures++; end
    tick();
    @(negedge clock);
    checks += 3;
    if (out_data !== 8'hA2) begin $display("FAIL bp_second: got 0x%02h required 0xA2", out_data); failures++; end
    if (count !== 2'd1) begin $display("FAIL bp_recover_count: got %0d required 1", count); failures++; end
    if (in_ready !== 1'b1) begin $display("FAIL bp_recover_ready: got %b required 1", in_ready); failures++; end
    tick();
    in_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (out_data !== 8'hA3 || out_valid !== 1'b1) begin
      $display("FAIL bp_third: got 0x%02h valid=%b required 0xA3/1", out_data, out_valid); failures++;
    end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    in_valid = 1'b1; in_data = 8'hB1; out_ready = 1'b0;
    tick();
    in_data = 8'hB2;
    tick();
    discard = 1'b1; in_data = 8'hB3;
    tick();
    discard = 1'b0; in_valid = 1'b0;
    @(negedge clock);
    checks += 4;
    if (out_valid !== 1'b0) begin $display("FAIL flush_valid: got %b required 0", out_valid); failures++; end
    if (count !== 2'd0) begin $display("FAIL flush_count: got %0d required 0", count); failures++; end
    if (out_data !== 8'h00) begin $display("FAIL flush_data: got 0x%02h required 0x00", out_data); failures++; end
    if (flushed !== 1'b1) begin $display("FAIL flush_pulse: got %b required 1", flushed); failures++; end
    tick();
    @(negedge clock);
    checks++;
    if (flushed !== 1'b0) begin $display("FAIL flush_pulse_end: got %b required 0", flushed); failures++; end
    // discard while EMPTY drops the same-cycle input and reports nothing
    in_valid = 1'b1; in_data = 8'h77; discard = 1'b1;
    tick();
    in_valid = 1'b0; discard = 1'b0;
    @(negedge clock);
    checks += 2;
    if (count !== 2'd0) begin $display("FAIL flush_empty_drop: got %0d required 0", count); failures++; end
    if (flushed !== 1'b0) begin $display("FAIL flush_empty_pulse: got %b required 0", flushed); failures++; end
  endtask

  task automatic test_reset_midstream();
    in_valid = 1'b1; in_data = 8'hD1; out_ready = 1'b0;
    tick();
    in_data = 8'hD2;
    tick();
    reset = 1'b0; in_data = 8'hD3;
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b0) begin $display("FAIL rstm_gate: got %b required 0", in_ready); failures++; end
    tick();
    @(negedge clock);
    checks += 3;
    if (out_valid !== 1'b0 || count !== 2'd0) begin
      $display("FAIL rstm_state: got valid=%b count=%0d required 0/0", out_valid, count); failures++;
    end
    if (out_data !== 8'h00 || flushed !== 1'b0) begin
      $display("FAIL rstm_outs: got data=0x%02h flushed=%b required 0x00/0", out_data, flushed); failures++;
    end
    if (in_ready !== 1'b0) begin $display("FAIL rstm_held_ready: got %b required 0", in_ready); failures++; end
    tick();
    reset = 1'b1; in_data = 8'hD5; out_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b1) begin $display("FAIL rstm_release_ready: got %b required 1", in_ready); failures++; end
    tick();
    in_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (out_data !== 8'hD5 || out_valid !== 1'b1) begin
      $display("FAIL rstm_first: got 0x%02h valid=%b required 0xD5/1", out_data, out_valid); failures++;
    end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_skid0();
    s0_in_valid = 1'b1; s0_in_data = 8'hC3; s0_out_ready = 1'b0;
    tick();
    s0_in_data = 8'hC9;
    @(negedge clock);
    checks += 2;
    if (s0_count !== 2'd1 || s0_out_data !== 8'hC3) begin
      $display("FAIL s0_hold: got count=%0d data=0x%02h required 1/0xC3", s0_count, s0_out_data); failures++;
    end
    if (s0_in_ready !== 1'b0) begin $display("FAIL s0_stall_ready: got %b required 0", s0_in_ready); failures++; end
    tick();
    s0_out_ready = 1'b1; s0_in_data = 8'hC4;
    @(negedge clock);
    checks++;
    if (s0_in_ready !== 1'b1) begin $display("FAIL s0_comb_ready: got %b required 1", s0_in_ready); failures++; end
    tick();
    s0_out_ready = 1'b0; s0_in_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (s0_out_data !== 8'hC4 || s0_count !== 2'd1) begin
      $display("FAIL s0_swap: got 0x%02h count=%0d required 0xC4/1", s0_out_data, s0_count); failures++;
    end
    tick();
    s0_out_ready = 1'b1;
    tick();
    s0_out_ready = 1'b0;
    @(negedge clock);
    checks++;
    if (s0_out_valid !== 1'b0 || s0_out_data !== 8'h00) begin
      $display("FAIL s0_drain: got valid=%b data=0x%02h required 0/0x00", s0_out_valid, s0_out_data); failures++;
    end
  endtask

  task automatic test_no_clear();
    k_in_valid = 1'b1; k_in_data = 8'h5A; k_out_ready = 1'b1;
    tick();
    k_in_valid = 1'b0;
    tick();
    k_out_ready = 1'b0;
    @(negedge clock);
    checks++;
    if (k_out_valid !== 1'b0 || k_out_data !== 8'h5A) begin
      $display("FAIL nc_drain: got valid=%b data=0x%02h required 0/0x5A", k_out_valid, k_out_data); failures++;
    end
    k_discard = 1'b1;
    tick();
    k_discard = 1'b0;
    @(negedge clock);
    checks++;
    if (k_out_data !== 8'h5A || k_flushed !== 1'b0) begin
      $display("FAIL nc_discard_empty: got data=0x%02h flushed=%b required 0x5A/0", k_out_data, k_flushed); failures++;
    end
    k_in_valid = 1'b1; k_in_data = 8'h6B;
    tick();
    k_in_valid = 1'b0; k_discard = 1'b1;
    tick();
    k_discard = 1'b0;
    @(negedge clock);
    checks++;
    if (k_out_data !== 8'h6B || k_flushed !== 1'b1 || k_count !== 2'd0) begin
      $display("FAIL nc_discard_held: got data=0x%02h flushed=%b count=%0d required 0x6B/1/0",
               k_out_data, k_flushed, k_count); failures++;
    end
  endtask

  task automatic test_random();
    bit fired;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      fired = in_valid && in_ready;
      tick();
      if (!in_valid || fired) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 8'($urandom_range(0, 255));
      end
      out_ready = 1'($urandom_range(0, 3) != 0);
    end
    @(negedge clock);
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    tick();
    @(negedge clock);
    checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      $display("FAIL rand_drain: got pending=%0d valid=%b required 0/0", exp_q.size(), out_valid); failures++;
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    test_skid0();
    test_no_clear();
    test_random();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
